sram_access_ctrl: RTL and testbench
===================================

Name: sram_access_ctrl

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit SRAM.
- Takes the MEM_R_EN/MEM_W_EN, ALU result (address) and Val_Rm (store data) held in the EXE/MEM pipeline register.
- Splits each 32-bit access into two 16-bit SRAM phases and asserts freeze. Freeze drives the enables of all pipeline registers, so the pipeline holds until the access completes.

Parameters:
- BASE_ADDR, 32'd1024, byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 2, cycles per 16-bit phase; legal range 1..15.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  load request (MEM_R_EN from EXE/MEM register).
- wr_en  input  1  store request (MEM_W_EN from EXE/MEM register).
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (Val_Rm).
- read_data  output  32  loaded word; valid while ready=1 after a read.
- ready  output  1  access complete, or no access pending.
- freeze  output  1  equals ~ready; hold all pipeline stage registers.
- sram_addr  output  SRAM_AW  halfword address.
- sram_dq_o  output  16  write data to SRAM.
- sram_dq_i  input  16  read data from SRAM.
- sram_dq_oe  output  1  drive sram_dq_o onto the pad.
- sram_we_n  output  1  active-low SRAM write strobe.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, cnt=0.
  - read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1.
  - ready follows the IDLE rule below.
- Reset mid-access: abort immediately, state=IDLE, we_n=1, oe=0. Partial SRAM write is allowed; no retry.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en|wr_en).
  - If rd_en|wr_en: latch op (wr_en has priority when both are high), offset = address - BASE_ADDR, and write_data. Go to LO, cnt=0.
- Address mapping: sram_addr = {offset[SRAM_AW:2], half}, with half=0 in LO and 1 in HI. address[1:0] is ignored (word-aligned only). Offset wraps modulo 2^(SRAM_AW+1); no range check.
- LO: lasts exactly WAIT_CYCLES cycles, with cnt counting 0..WAIT_CYCLES-1.
  - Write: sram_dq_o = data[15:0], oe=1, we_n=0 on every LO cycle.
  - Read: oe=0, we_n=1; on the last LO cycle, read_data[15:0] <= sram_dq_i.
- HI: same as LO using data[31:16] / read_data[31:16]. Then go to DONE.
- Between LO and HI: we_n returns to 1 for zero cycles, i.e. the write strobe is continuous across the address change. This is acceptable for the target SRAM model.
- DONE: exactly one cycle; ready=1, oe=0, we_n=1; then IDLE.
- Latency: request seen in IDLE at cycle 0 → ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 5 at default), freeze high on cycles 0..2*WAIT_CYCLES.
- Inputs changing during LO/HI are ignored (latched copy used). The pipeline is frozen, so the inputs are stable anyway.
- Back-to-back accesses: a new request in the cycle after DONE starts immediately; there is no bubble beyond DONE.
- read_data holds its value until the next read's LO capture. Writes do not modify read_data.
- Outputs sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, read_data are registered; ready/freeze are combinational from state and inputs.

Decomposition:
- Shared package: state encoding (IDLE=0, LO=1, HI=2, DONE=3), BASE_ADDR default, SRAM data width 16.
- No sub-module needed; the phase counter stays inline.

Test Plan:
- Idle: rd_en=wr_en=0 for 10 cycles → ready=1, freeze=0, we_n=1, oe=0 throughout.
- Write: wr_en=1, address=1024+8, write_data=32'hDEADBEEF, WAIT_CYCLES=2 → two cycles with sram_addr=4, dq_o=16'hBEEF, we_n=0; then two cycles with sram_addr=5, dq_o=16'hDEAD; ready=1 at cycle 5.
- Read: SRAM model with halfword 4=16'h5678 and 5=16'h1234; rd_en=1, address=1032 → read_data=32'h12345678 at cycle 5; freeze high for cycles 0..4.
- Both enables: rd_en=wr_en=1 → write performed, read_data unchanged.
- Back-to-back: store then load of the same address, consecutive requests → second starts the cycle after DONE; load returns the stored value.
- Reset mid-access: assert rst during HI of a write → we_n=1, oe=0 within the same cycle; after release, ready=1 and state=IDLE.

Source files
------------

// File: rtl/sram_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller.
//   state_e           : controller FSM encoding (IDLE=0, LO=1, HI=2, DONE=3)
//   DEFAULT_BASE_ADDR : byte address that maps to SRAM halfword 0
//   SRAM_DW           : external SRAM data width
package sram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
  localparam int          SRAM_DW           = 16;

endpackage

// File: rtl/sram_access_ctrl.sv
// Multi-cycle controller between the MEM stage and a 16-bit external SRAM.
// Each 32-bit load/store is split into a low-halfword phase (LO) and a
// high-halfword phase (HI), each WAIT_CYCLES long, followed by one DONE cycle.
// While an access is in flight, freeze holds every pipeline register.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   rd_en, wr_en    : load / store request from the EXE/MEM register
//   address         : byte address (ALU result), word aligned
//   write_data      : store data (Val_Rm)
//   read_data       : loaded word, valid while ready=1 after a read
//   ready, freeze   : access complete (or none pending) / its complement
//   sram_addr       : SRAM halfword address
//   sram_dq_o/_i    : SRAM write / read data
//   sram_dq_oe      : drive sram_dq_o onto the pad
//   sram_we_n       : active-low SRAM write strobe
//   state_dbg       : current FSM state (debug visibility)
//
// Handshake: a request is any cycle in IDLE with rd_en|wr_en high; the
// request is accepted in that same cycle (ready=0 from then on) and the
// requester must keep it asserted until ready=1. ready=1 in DONE completes
// the access; if the request is still high in the following IDLE cycle a
// new access starts there.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic [1:0]         state_dbg
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e             state;
  logic [3:0]         cnt;
  logic               is_write;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        data_q;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] word_d;
  logic               req;
  logic               last;
  logic               unused_offset_bits;

  // Offset wraps naturally; only the word-address bits reach the SRAM,
  // byte-lane bits and anything above the SRAM range are dropped.
  assign offset             = address - BASE_ADDR;
  assign word_d             = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign req  = rd_en | wr_en;
  assign last = (cnt == LAST_CNT);

  // Outputs are registered from the next state, so the SRAM pins carry the
  // LO-phase values during the first LO cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_write   <= 1'b0;
      word_q     <= '0;
      data_q     <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state     <= ST_LO;
            cnt       <= '0;
            // Store wins when both enables are high.
            is_write  <= wr_en;
            word_q    <= word_d;
            data_q    <= write_data;
            sram_addr <= {word_d, 1'b0};
            if (wr_en) begin
              sram_dq_o  <= write_data[15:0];
              sram_dq_oe <= 1'b1;
              sram_we_n  <= 1'b0;
            end else begin
              sram_dq_oe <= 1'b0;
              sram_we_n  <= 1'b1;
            end
          end
        end
        ST_LO: begin
          if (last) begin
            state     <= ST_HI;
            cnt       <= '0;
            sram_addr <= {word_q, 1'b1};
            // Strobe stays low across the address change on writes.
            if (is_write) sram_dq_o <= data_q[31:16];
            else          read_data[15:0] <= sram_dq_i;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_HI: begin
          if (last) begin
            state      <= ST_DONE;
            cnt        <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!is_write) read_data[31:16] <= sram_dq_i;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // In IDLE a new request drops ready in the same cycle so the pipeline
  // freezes before it can advance past the memory instruction.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE: ready = ~req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign freeze    = ~ready;
  assign state_dbg = state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [1:0]  state_dbg;

  int total;
  int bad;

  // SRAM model: small array, combinational read, write on clock edge.
  logic [15:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .freeze     (freeze),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .state_dbg  (state_dbg)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (!sram_we_n && sram_dq_oe) mem[sram_addr[3:0]] <= sram_dq_o;
  end
  assign sram_dq_i = mem[sram_addr[3:0]];

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    write_data = '0;
    pl_en      = 1'b0;
    pl_addr    = '0;
    pl_data    = '0;

    // Reset values
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_freeze", freeze, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_o", sram_dq_o, 0);
    chk("rst_state", state_dbg, 0);
    step();
    rst = 1'b0;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", ready, 1);
      chk("idle_freeze", freeze, 0);
      chk("idle_we_n", sram_we_n, 1);
      chk("idle_oe", sram_dq_oe, 0);
    end

    // Write 0xDEADBEEF to byte 1032 -> halfwords 4/5
    step(); // cycle 0
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hDEADBEEF;
    #1;
    chk("wr_c0_ready", ready, 0);
    chk("wr_c0_freeze", freeze, 1);
    step(); // cycle 1: LO; scramble inputs, latched copy must be used
    address = 32'h0; write_data = 32'h0;
    #1;
    chk("wr_c1_state", state_dbg, 1);
    chk("wr_c1_addr", sram_addr, 4);
    chk("wr_c1_dq", sram_dq_o, 32'hBEEF);
    chk("wr_c1_we_n", sram_we_n, 0);
    chk("wr_c1_oe", sram_dq_oe, 1);
    chk("wr_c1_freeze", freeze, 1);
    step(); // cycle 2
    chk("wr_c2_addr", sram_addr, 4);
    chk("wr_c2_we_n", sram_we_n, 0);
    chk("wr_c2_ready", ready, 0);
    step(); // cycle 3: HI
    chk("wr_c3_state", state_dbg, 2);
    chk("wr_c3_addr", sram_addr, 5);
    chk("wr_c3_dq", sram_dq_o, 32'hDEAD);
    chk("wr_c3_we_n", sram_we_n, 0);
    step(); // cycle 4
    chk("wr_c4_addr", sram_addr, 5);
    chk("wr_c4_we_n", sram_we_n, 0);
    chk("wr_c4_freeze", freeze, 1);
    step(); // cycle 5: DONE
    chk("wr_c5_state", state_dbg, 3);
    chk("wr_c5_ready", ready, 1);
    chk("wr_c5_freeze", freeze, 0);
    chk("wr_c5_we_n", sram_we_n, 1);
    chk("wr_c5_oe", sram_dq_oe, 0);
    wr_en = 1'b0;
    step(); // cycle 6: IDLE
    chk("wr_c6_state", state_dbg, 0);
    chk("wr_c6_ready", ready, 1);
    chk("wr_mem4", mem[4], 32'hBEEF);
    chk("wr_mem5", mem[5], 32'hDEAD);

    // Read 1032 with halfword 4=0x5678, 5=0x1234
    preload(4'd4, 16'h5678);
    preload(4'd5, 16'h1234);
    step(); // cycle 0
    rd_en = 1'b1; address = 32'd1032;
    #1;
    chk("rd_c0_freeze", freeze, 1);
    step(); // cycle 1
    chk("rd_c1_addr", sram_addr, 4);
    chk("rd_c1_we_n", sram_we_n, 1);
    chk("rd_c1_oe", sram_dq_oe, 0);
    chk("rd_c1_freeze", freeze, 1);
    step(); // cycle 2
    chk("rd_c2_freeze", freeze, 1);
    step(); // cycle 3
    chk("rd_c3_addr", sram_addr, 5);
    chk("rd_c3_rdata_lo", read_data[15:0], 32'h5678);
    step(); // cycle 4
    chk("rd_c4_freeze", freeze, 1);
    step(); // cycle 5
    chk("rd_c5_ready", ready, 1);
    chk("rd_c5_rdata", read_data, 32'h12345678);
    rd_en = 1'b0;
    step();
    chk("rd_hold_rdata", read_data, 32'h12345678);

    // Both enables: store wins, read_data untouched (1040 -> halfwords 8/9)
    step(); // cycle 0
    rd_en = 1'b1; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    #1;
    step(); // cycle 1
    chk("both_c1_addr", sram_addr, 8);
    chk("both_c1_we_n", sram_we_n, 0);
    chk("both_c1_dq", sram_dq_o, 32'hF00D);
    step(); step(); step();
    step(); // cycle 5
    chk("both_c5_ready", ready, 1);
    chk("both_c5_rdata", read_data, 32'h12345678);
    rd_en = 1'b0; wr_en = 1'b0;
    step();
    chk("both_mem8", mem[8], 32'hF00D);
    chk("both_mem9", mem[9], 32'hCAFE);

    // Back-to-back: store then load of 1048 (halfwords 12/13)
    step(); // cycle 0
    wr_en = 1'b1; address = 32'd1048; write_data = 32'hA5A53C3C;
    #1;
    step(); step(); step(); step();
    step(); // cycle 5: DONE
    chk("b2b_c5_ready", ready, 1);
    wr_en = 1'b0; rd_en = 1'b1;
    step(); // cycle 6: IDLE with load pending
    chk("b2b_c6_state", state_dbg, 0);
    chk("b2b_c6_ready", ready, 0);
    step(); // cycle 7: load LO
    chk("b2b_c7_state", state_dbg, 1);
    chk("b2b_c7_addr", sram_addr, 12);
    chk("b2b_c7_we_n", sram_we_n, 1);
    step(); step(); step();
    step(); // cycle 11: DONE
    chk("b2b_c11_ready", ready, 1);
    chk("b2b_c11_rdata", read_data, 32'hA5A53C3C);
    rd_en = 1'b0;
    step();

    // Reset during the HI phase of a write
    step(); // cycle 0
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
    #1;
    step(); step();
    step(); // cycle 3: HI
    chk("rstm_c3_state", state_dbg, 2);
    chk("rstm_c3_we_n", sram_we_n, 0);
    rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("rstm_we_n", sram_we_n, 1);
    chk("rstm_oe", sram_dq_oe, 0);
    chk("rstm_state", state_dbg, 0);
    step();
    rst = 1'b0;
    step();
    chk("rstm_post_ready", ready, 1);
    chk("rstm_post_state", state_dbg, 0);
    chk("rstm_post_freeze", freeze, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
